// File: rtl/decode_pkg.sv
// Shared encodings and instruction field positions for the decode stage.
// Field and immediate bounds used by decode_stage_pipe and decode_regfile.
package decode_pkg;

  localparam logic [1:0] IMM_I  = 2'd0;
  localparam logic [1:0] IMM_D  = 2'd1;
  localparam logic [1:0] IMM_CB = 2'd2;
  localparam logic [1:0] IMM_B  = 2'd3;

  localparam int FLD_W  = 5;
  localparam int RN_LSB = 5;
  localparam int RM_LSB = 16;
  localparam int RT_LSB = 0;

  localparam int IMM_I_MSB  = 21;
  localparam int IMM_I_LSB  = 10;
  localparam int IMM_D_MSB  = 20;
  localparam int IMM_D_LSB  = 12;
  localparam int IMM_CB_MSB = 23;
  localparam int IMM_CB_LSB = 5;
  localparam int IMM_B_MSB  = 25;
  localparam int IMM_B_LSB  = 0;

  localparam int IMM_I_W  = IMM_I_MSB - IMM_I_LSB + 1;
  localparam int IMM_D_W  = IMM_D_MSB - IMM_D_LSB + 1;
  localparam int IMM_CB_W = IMM_CB_MSB - IMM_CB_LSB + 1;
  localparam int IMM_B_W  = IMM_B_MSB - IMM_B_LSB + 1;

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: two async reads, one write, hardwired zero reg.
// DECODE_BYPASS_EN makes a same-cycle write visible on the read ports.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = NUM_REGS - 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wa != ZR) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
`ifdef DECODE_BYPASS_EN
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
`endif
    if (ra1 == ZR) rd1 = '0;
    if (ra2 == ZR) rd2 = '0;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Clocked decode stage: regfile, immediates, load-use stall, valid/ready slot.
// Optional write-through read bypass under DECODE_BYPASS_EN.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = NUM_REGS - 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            reg2loc,
  input  logic [1:0]      imm_sel,
  input  logic            mem_read,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [AW-1:0]   ex_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_data1,
  output logic [XLEN-1:0] out_data2,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd,
  output logic            out_mem_read,
  output logic            stall
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [FLD_W-1:0] rn_f, rm_f, rt_f;
  logic [AW-1:0]    rn, rm, rt;
  logic [XLEN-1:0]  rd1, rd2, imm;
  logic [AW-1:0]    held_rn, held_rm;
  logic             hazard, slot_free, accept;

  assign rn_f = in_instr[RN_LSB +: FLD_W];
  assign rt_f = in_instr[RT_LSB +: FLD_W];
  assign rm_f = reg2loc ? rt_f : in_instr[RM_LSB +: FLD_W];
  assign rn   = rn_f[AW-1:0];
  assign rm   = rm_f[AW-1:0];
  assign rt   = rt_f[AW-1:0];

  decode_regfile #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra1(rn), .ra2(rm),
    .rd1(rd1), .rd2(rd2),
    .we(wb_en), .wa(wb_addr), .wd(wb_data)
  );

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I: imm = {{(XLEN-IMM_I_W){1'b0}},
                    in_instr[IMM_I_MSB:IMM_I_LSB]};
      IMM_D: imm = {{(XLEN-IMM_D_W){in_instr[IMM_D_MSB]}},
                    in_instr[IMM_D_MSB:IMM_D_LSB]};
      IMM_CB: imm = {{(XLEN-IMM_CB_W){in_instr[IMM_CB_MSB]}},
                     in_instr[IMM_CB_MSB:IMM_CB_LSB]};
      default: imm = {{(XLEN-IMM_B_W){in_instr[IMM_B_MSB]}},
                      in_instr[IMM_B_MSB:IMM_B_LSB]};
    endcase
  end

  assign hazard = in_valid & ex_valid & ex_mem_read & (ex_rd != ZR)
                & ((ex_rd == rn) | (ex_rd == rm));
  assign slot_free = !out_valid | out_ready;
  assign stall     = hazard & rst_n;
  assign in_ready  = slot_free & !hazard & !flush & rst_n;
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_instr    <= '0;
      out_data1    <= '0;
      out_data2    <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_mem_read <= 1'b0;
      held_rn      <= '0;
      held_rm      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_instr    <= in_instr;
      out_data1    <= rd1;
      out_data2    <= rd2;
      out_imm      <= imm;
      out_rd       <= rt;
      out_mem_read <= mem_read;
      held_rn      <= rn;
      held_rm      <= rm;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end else if (wb_en && wb_addr != ZR) begin
      // held slot picks up late writebacks to its sources
      if (wb_addr == held_rn) out_data1 <= wb_data;
      if (wb_addr == held_rm) out_data2 <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe.
// Expected values are hand-computed; bypass expectation follows DECODE_BYPASS_EN.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        reg2loc, mem_read;
  logic [1:0]  imm_sel;
  logic        ex_valid, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_data1, out_data2, out_imm;
  logic [31:0] out_instr;
  logic [4:0]  out_rd;
  logic        out_mem_read, stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .reg2loc(reg2loc), .imm_sel(imm_sel),
    .mem_read(mem_read),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_imm(out_imm), .out_rd(out_rd),
    .out_mem_read(out_mem_read), .stall(stall)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd,
                                     input logic [4:0] rn,
                                     input logic [4:0] rm);
    return {11'd0, rm, 6'd0, rn, rd};
  endfunction

  logic [63:0] exp_byp;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_instr = '0; in_pc = '0;
    reg2loc = 0; imm_sel = 0; mem_read = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    flush = 0; out_ready = 1;
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_data1", out_data1, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // seed X5, X7, X3
    wb_en = 1; wb_addr = 5; wb_data = 64'h1234; tick();
    wb_addr = 7; wb_data = 64'h11; tick();
    wb_addr = 3; wb_data = 64'h33; tick();
    wb_en = 0;

    // basic accept, rn=5 rm=6 rd=2
    in_valid = 1; in_pc = 64'h1000; in_instr = mk(2, 5, 6);
    mem_read = 1;
    #1;
    chk("acc_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("acc_valid", {63'd0, out_valid}, 64'd1);
    chk("acc_data1", out_data1, 64'h1234);
    chk("acc_data2", out_data2, 64'd0);
    chk("acc_pc", out_pc, 64'h1000);
    chk("acc_rd", {59'd0, out_rd}, 64'd2);
    chk("acc_imm", out_imm, 64'h180);
    chk("acc_mrd", {63'd0, out_mem_read}, 64'd1);
    mem_read = 0;

    // same-cycle writeback to X7 while reading rn=7
`ifdef DECODE_BYPASS_EN
    exp_byp = 64'hAA;
`else
    exp_byp = 64'h11;
`endif
    wb_en = 1; wb_addr = 7; wb_data = 64'hAA;
    in_pc = 64'h1004; in_instr = mk(1, 7, 5);
    tick();
    wb_en = 0;
    chk("byp_data1", out_data1, exp_byp);
    chk("byp_data2", out_data2, 64'h1234);

    // load-use hazard on rm=3
    ex_valid = 1; ex_mem_read = 1; ex_rd = 3;
    in_pc = 64'h1008; in_instr = mk(4, 1, 3);
    #1;
    chk("hz_stall", {63'd0, stall}, 64'd1);
    chk("hz_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("hz_bubble", {63'd0, out_valid}, 64'd0);
    ex_mem_read = 0;
    #1;
    chk("hz_clr_stall", {63'd0, stall}, 64'd0);
    tick();
    chk("hz_acc_valid", {63'd0, out_valid}, 64'd1);
    chk("hz_acc_data2", out_data2, 64'h33);
    chk("hz_acc_pc", out_pc, 64'h1008);

    // load in EX targeting zero register never stalls
    ex_mem_read = 1; ex_rd = 31;
    in_instr = mk(4, 31, 31);
    #1;
    chk("hz_zero", {63'd0, stall}, 64'd0);
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0;

    // hold slot with rn=4 then refresh from writeback
    in_pc = 64'h2000; in_instr = mk(9, 4, 6);
    tick();
    chk("hold_acc_d1", out_data1, 64'd0);
    out_ready = 0; in_valid = 1; in_pc = 64'h2004;
    in_instr = mk(1, 5, 5);
    wb_en = 1; wb_addr = 4; wb_data = 64'h55;
    #1;
    chk("hold_ready", {63'd0, in_ready}, 64'd0);
    tick();
    wb_en = 0;
    chk("hold_d1", out_data1, 64'h55);
    chk("hold_pc", out_pc, 64'h2000);
    chk("hold_instr", {32'd0, out_instr}, {32'd0, mk(9, 4, 6)});
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1;

    // immediate formats
    imm_sel = 3; in_instr = 32'h03FF_FFFF; tick();
    chk("imm_b", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    imm_sel = 0; in_instr = 32'h003F_FC00; tick();
    chk("imm_i", out_imm, 64'h0000_0000_0000_0FFF);
    imm_sel = 1; in_instr = 32'h0010_0000; tick();
    chk("imm_d", out_imm, 64'hFFFF_FFFF_FFFF_FF00);
    imm_sel = 2; in_instr = 32'h0080_0000; tick();
    chk("imm_cb", out_imm, 64'hFFFF_FFFF_FFFC_0000);
    imm_sel = 0;

    // flush with a valid slot and incoming instruction; write X31
    flush = 1; in_instr = mk(1, 5, 5);
    wb_en = 1; wb_addr = 31; wb_data = 64'hDEAD;
    #1;
    chk("fl_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 0; wb_en = 0;
    chk("fl_valid", {63'd0, out_valid}, 64'd0);

    // X31 reads zero; reg2loc=1 picks instr[4:0]
    reg2loc = 1; in_pc = 64'h3000;
    in_instr = mk(5, 31, 0);
    tick();
    chk("x31_zero", out_data1, 64'd0);
    chk("r2l_data2", out_data2, 64'h1234);
    chk("r2l_valid", {63'd0, out_valid}, 64'd1);
    reg2loc = 0;

    // async reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_pc", out_pc, 64'd0);
    chk("mrst_d2", out_data2, 64'd0);
    chk("mrst_imm", out_imm, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_instr = mk(1, 5, 3);
    tick();
    chk("mrst_rf5", out_data1, 64'd0);
    chk("mrst_rf3", out_data2, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised, clocked successor to the combinational decode stage.
- Holds the architectural register file: two read ports and one writeback port.
- Extracts register fields and extends immediates per format.
- Detects load-use hazards and presents operands to Execution through a registered valid/ready pipeline slot.
- Sits between fetch and Execution; control signals (reg2loc, imm_sel, mem_read) arrive from cpu_control.

Parameters:
- XLEN, 64, data/address width of registers and PC.
- NUM_REGS, 32, register count; legal values 16 or 32; fields use the low AW = $clog2(NUM_REGS) bits.
- ZERO_REG, NUM_REGS-1, index hardwired to zero (XZR).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- reg2loc  in  1  0: second source = instr[20:16]; 1: instr[4:0]
- imm_sel  in  2  immediate format
- mem_read  in  1  this instruction is a load
- ex_valid, ex_mem_read  in  1 each  instruction in EX is valid / is a load
- ex_rd  in  AW  destination of EX instruction
- wb_en  in  1  writeback strobe
- wb_addr  in  AW  writeback register
- wb_data  in  XLEN  writeback value
- flush  in  1  branch taken; kill held and incoming instruction
- out_valid  out  1  slot holds an instruction
- out_ready  in  1  Execution accepts the slot
- out_pc  out  XLEN  held PC
- out_instr  out  32  held instruction
- out_data1, out_data2  out  XLEN each  source operands
- out_imm  out  XLEN  extended immediate
- out_rd  out  AW  instr[4:0]
- out_mem_read  out  1  held load flag
- stall  out  1  hazard stall active this cycle

Behaviour:
- Reset (rst_n low, async): all registers 0; out_valid=0; all out_* = 0; stall=0.
- Fields:
  - rn = instr[9:5]
  - rm = reg2loc ? instr[4:0] : instr[20:16]
  - Each field truncated to AW bits.
- Immediate, unshifted:
  - imm_sel 0: I-type, zero-extend instr[21:10].
  - imm_sel 1: D-type, sign-extend instr[20:12].
  - imm_sel 2: CB-type, sign-extend instr[23:5].
  - imm_sel 3: B-type, sign-extend instr[25:0].
- Register reads:
  - ZERO_REG always reads 0.
  - Writes to ZERO_REG are ignored.
  - wb writes at the rising clk edge.
- hazard = in_valid & ex_valid & ex_mem_read & (ex_rd != ZERO_REG) & (ex_rd==rn | ex_rd==rm). stall = hazard.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept (in_valid & in_ready): slot captures pc, instr, operands, imm, rd and mem_read at the edge. out_valid=1 next cycle. Latency is 1 cycle.
- Hazard while the slot is free (!out_valid | out_ready): out_valid<=0, i.e. a bubble. The instruction stays at the input and is accepted once ex_mem_read/ex_rd clear.
- Slot held (out_valid & !out_ready): all out_* stable, except refresh. If wb_en and wb_addr matches the held rn/rm (non-zero reg), the matching out_data* loads wb_data at the edge. If both sources match, both update.
- Flush: out_valid<=0 at the next edge; nothing accepted that cycle. Flush overrides hazard and accept. Register file writes still occur.
- Slot drained with no new accept: out_valid<=0.
- Reset mid-operation: the slot is discarded and the register file is cleared.

Optional Feature:
- DECODE_BYPASS_EN defined: a read of wb_addr in the cycle wb_en is asserted returns wb_data (write-through).
- Undefined: the read returns the pre-write value. Held-slot refresh is still performed.

Decomposition:
- decode_pkg holds:
  - IMM_I/IMM_D/IMM_CB/IMM_B encodings.
  - Field bit positions (RN_LSB=5, RM_LSB=16, RT_LSB=0).
  - Immediate field bounds.
- Sub-module decode_regfile:
  - NUM_REGS x XLEN array with async reset.
  - Two combinational read ports, optional bypass, zero-register handling, one write port.

Test Plan:
- Write X5=0x1234 via wb, then accept ADD with rn=5 and out_ready=1 → next cycle out_valid=1, out_data1=0x1234, out_pc=in_pc.
- wb_en to X7=0xAA in the same cycle an instruction reads rn=7:
  - bypass on → out_data1=0xAA.
  - bypass off → out_data1=old value.
- ex_valid=1, ex_mem_read=1, ex_rd=3 and input reads rm=3 (reg2loc=0) → stall=1, in_ready=0, bubble (out_valid=0). Next cycle with ex_mem_read=0 → accepted.
- out_ready=0 holding rn=4; wb writes X4=0x55 → out_data1 becomes 0x55; out_pc/out_instr unchanged.
- Immediates, imm_sel 3 with instr[25:0]=0x3FFFFFF → out_imm=all ones. imm_sel 0 with instr[21:10]=0xFFF → out_imm=0xFFF.
- flush=1 with out_valid=1 and in_valid=1 → out_valid=0 next cycle, in_ready=0. Write to X31 ignored (reads 0). rst_n low mid-stream → all outputs 0 immediately.
